wb_arbiter_2m: RTL and testbench

//  Two-master, one-slave Wishbone (pipelined) arbiter placed in front of a generated register bank.
//  It lets a CPU and a DMA/debug master share one CSR slave.

---
 rtl/wb_arb_pkg.sv | 30 +++
 rtl/wb_arb_watchdog.sv | 42 ++++
 rtl/wb_arbiter_2m.sv | 195 +++++++++++++++++++
 tb/tb_wb_arbiter_2m.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types for the two-master Wishbone arbiter.
//   arb_state_t : arbiter FSM states (IDLE, GRANT, WAIT)
//   GNT_*       : one-hot grant encodings driven on grant_o
//   rr_pick     : round-robin winner selection from the two CYC requests
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    // req[0] is master 0's CYC, req[1] master 1's. last is the index of the
    // master granted most recently; on a tie the other master wins.
    function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last);
        if (req == 2'b11) begin
            return last ? GNT_M0 : GNT_M1;
        end else if (req[0]) begin
            return GNT_M0;
        end else if (req[1]) begin
            return GNT_M1;
        end
        return GNT_NONE;
    endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Saturating cycle counter used to detect hung slave transfers.
//   clk    : clock
//   srst   : synchronous active-high reset
//   clr    : clear the count to zero (takes priority over en)
//   en     : count up by one, holding at TIMEOUT
//   expire : high while the count equals TIMEOUT
module wb_arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic srst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (en && (count_reg != LIMIT)) begin
            count_next = count_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign expire = (count_reg == LIMIT);

endmodule

// File: rtl/wb_arbiter_2m.sv
// Two-master, one-slave pipelined Wishbone arbiter with round-robin grant per
// bus cycle, a single outstanding transfer and a watchdog that answers hung
// transfers with ERR.
//   clk_i, rst_i                : clock, synchronous active-high reset
//   m0_* / m1_*                 : master ports (cyc/stb/we/adr/sel/dat in,
//                                 dat/ack/err/stall out)
//   s_*                         : slave port (cyc/stb/we/adr/sel/dat out,
//                                 dat/ack/err/stall in)
//   grant_o                     : one-hot current grant, 00 when idle
module wb_arbiter_2m
    import wb_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                m0_cyc_i,
    input  logic                m0_stb_i,
    input  logic                m0_we_i,
    input  logic [ADDR_W-1:0]   m0_adr_i,
    input  logic [DATA_W/8-1:0] m0_sel_i,
    input  logic [DATA_W-1:0]   m0_dat_i,
    output logic [DATA_W-1:0]   m0_dat_o,
    output logic                m0_ack_o,
    output logic                m0_err_o,
    output logic                m0_stall_o,
    input  logic                m1_cyc_i,
    input  logic                m1_stb_i,
    input  logic                m1_we_i,
    input  logic [ADDR_W-1:0]   m1_adr_i,
    input  logic [DATA_W/8-1:0] m1_sel_i,
    input  logic [DATA_W-1:0]   m1_dat_i,
    output logic [DATA_W-1:0]   m1_dat_o,
    output logic                m1_ack_o,
    output logic                m1_err_o,
    output logic                m1_stall_o,
    output logic                s_cyc_o,
    output logic                s_stb_o,
    output logic                s_we_o,
    output logic [ADDR_W-1:0]   s_adr_o,
    output logic [DATA_W/8-1:0] s_sel_o,
    output logic [DATA_W-1:0]   s_dat_o,
    input  logic [DATA_W-1:0]   s_dat_i,
    input  logic                s_ack_i,
    input  logic                s_err_i,
    input  logic                s_stall_i,
    output logic [1:0]          grant_o
);

    // Master inputs gathered into arrays so the granted one can be indexed.
    logic [1:0]          cyc;
    logic [1:0]          stb;
    logic [1:0]          we;
    logic [ADDR_W-1:0]   adr  [2];
    logic [DATA_W/8-1:0] sel  [2];
    logic [DATA_W-1:0]   wdat [2];

    assign cyc     = {m1_cyc_i, m0_cyc_i};
    assign stb     = {m1_stb_i, m0_stb_i};
    assign we      = {m1_we_i,  m0_we_i};
    assign adr[0]  = m0_adr_i;
    assign adr[1]  = m1_adr_i;
    assign sel[0]  = m0_sel_i;
    assign sel[1]  = m1_sel_i;
    assign wdat[0] = m0_dat_i;
    assign wdat[1] = m1_dat_i;

    arb_state_t state_reg, state_next;
    logic [1:0] grant_reg, grant_next;
    logic       last_reg, last_next;

    logic granted, gidx, g_cyc, g_stb;
    logic resp_ack, resp_err, stall_g;
    logic s_cyc_c, s_stb_c;
    logic wd_run, wd_expire;

    assign granted = |grant_reg;
    assign gidx    = grant_reg[1];
    assign g_cyc   = granted & cyc[gidx];
    assign g_stb   = granted & stb[gidx];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            grant_reg <= GNT_NONE;
            last_reg  <= 1'b1;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            last_reg  <= last_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        last_next  = last_reg;
        s_cyc_c    = 1'b0;
        s_stb_c    = 1'b0;
        resp_ack   = 1'b0;
        resp_err   = 1'b0;
        stall_g    = 1'b1;
        case (state_reg)
            IDLE: begin
                if (|cyc) begin
                    grant_next = rr_pick(cyc, last_reg);
                    state_next = GRANT;
                end
            end
            GRANT: begin
                s_cyc_c = g_cyc;
                s_stb_c = g_cyc & g_stb;
                stall_g = s_stall_i;
                if (!g_cyc) begin
                    state_next = IDLE;
                    grant_next = GNT_NONE;
                    last_next  = gidx;
                end else if (g_stb && !s_stall_i) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (!g_cyc) begin
                    // Master abandoned the cycle: drop it silently.
                    state_next = IDLE;
                    grant_next = GNT_NONE;
                    last_next  = gidx;
                end else if (s_ack_i || s_err_i) begin
                    // A real slave response wins over a coincident timeout.
                    s_cyc_c    = 1'b1;
                    resp_ack   = s_ack_i;
                    resp_err   = s_err_i;
                    state_next = GRANT;
                end else if (wd_expire) begin
                    // Drop CYC for one cycle so the slave aborts; any late
                    // ack then lands in GRANT where it is not routed.
                    resp_err   = 1'b1;
                    state_next = GRANT;
                end else begin
                    s_cyc_c = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = GNT_NONE;
            end
        endcase
    end

    // Count from the accept edge so expire rises TIMEOUT cycles after accept.
    assign wd_run = (state_next == WAIT);

    wb_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk_i),
        .srst   (rst_i),
        .clr    (~wd_run),
        .en     (wd_run),
        .expire (wd_expire)
    );

    assign s_cyc_o = s_cyc_c;
    assign s_stb_o = s_stb_c;
    assign s_we_o  = granted & we[gidx];
    assign s_adr_o = granted ? adr[gidx]  : '0;
    assign s_sel_o = granted ? sel[gidx]  : '0;
    assign s_dat_o = granted ? wdat[gidx] : '0;
    assign grant_o = grant_reg;

    logic [1:0]        ack_vec, err_vec, stall_vec;
    logic [DATA_W-1:0] rdat_vec [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_master
            assign ack_vec[gi]   = grant_reg[gi] & resp_ack;
            assign err_vec[gi]   = grant_reg[gi] & resp_err;
            assign stall_vec[gi] = grant_reg[gi] ? stall_g : 1'b1;
            assign rdat_vec[gi]  = grant_reg[gi] ? s_dat_i : '0;
        end
    endgenerate

    assign m0_ack_o   = ack_vec[0];
    assign m0_err_o   = err_vec[0];
    assign m0_stall_o = stall_vec[0];
    assign m0_dat_o   = rdat_vec[0];
    assign m1_ack_o   = ack_vec[1];
    assign m1_err_o   = err_vec[1];
    assign m1_stall_o = stall_vec[1];
    assign m1_dat_o   = rdat_vec[1];

endmodule

// File: tb/tb_wb_arbiter_2m.sv
module tb_wb_arbiter_2m;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst;

    logic [1:0]    m_cyc, m_stb, m_we;
    logic [AW-1:0] m_adr  [2];
    logic [SW-1:0] m_sel  [2];
    logic [DW-1:0] m_wdat [2];

    logic [DW-1:0] m0_rdat, m1_rdat;
    logic m0_ack, m0_err, m0_stall, m1_ack, m1_err, m1_stall;

    logic          s_cyc, s_stb, s_we;
    logic [AW-1:0] s_adr;
    logic [SW-1:0] s_sel;
    logic [DW-1:0] s_wdat, s_rdat;
    logic          s_ack, s_err, s_stall;
    logic [1:0]    grant;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wb_arbiter_2m #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_we_i(m_we[0]),
        .m0_adr_i(m_adr[0]), .m0_sel_i(m_sel[0]), .m0_dat_i(m_wdat[0]),
        .m0_dat_o(m0_rdat), .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_stall_o(m0_stall),
        .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_we_i(m_we[1]),
        .m1_adr_i(m_adr[1]), .m1_sel_i(m_sel[1]), .m1_dat_i(m_wdat[1]),
        .m1_dat_o(m1_rdat), .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_stall_o(m1_stall),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr),
        .s_sel_o(s_sel), .s_dat_o(s_wdat), .s_dat_i(s_rdat),
        .s_ack_i(s_ack), .s_err_i(s_err), .s_stall_i(s_stall),
        .grant_o(grant)
    );

    typedef struct {
        int          m;
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdat;
        int          lat;    // cycles after accept when the slave responds
        int          resp;   // 0 ack, 1 err, 2 never
        logic [31:0] rdata;
        logic        e_ack;
        logic        e_err;
        int          e_lat;
        logic [31:0] e_rdat;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    function automatic logic f_ack(input int m);
        return (m == 0) ? m0_ack : m1_ack;
    endfunction

    function automatic logic f_err(input int m);
        return (m == 0) ? m0_err : m1_err;
    endfunction

    function automatic logic [31:0] f_dat(input int m);
        return (m == 0) ? m0_rdat : m1_rdat;
    endfunction

    task automatic drive_m(input int m, input logic cyc, input logic stb, input logic we,
                           input logic [31:0] adr, input logic [31:0] dat);
        m_cyc[m]  = cyc;
        m_stb[m]  = stb;
        m_we[m]   = we;
        m_adr[m]  = adr;
        m_sel[m]  = 4'hF;
        m_wdat[m] = dat;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        s_ack = 1'b0; s_err = 1'b0; s_stall = 1'b0; s_rdat = 32'h0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic        got_ack, got_err;
        logic [31:0] got_dat, seen_adr;
        int          got_lat;
        drive_m(v.m, 1'b1, 1'b1, v.we, v.adr, v.wdat);
        s_stall = 1'b0; s_ack = 1'b0; s_err = 1'b0;
        step();
        settle();
        seen_adr = s_adr;
        step();
        m_stb[v.m] = 1'b0;
        got_lat = -1; got_ack = 1'b0; got_err = 1'b0; got_dat = 32'h0;
        for (int k = 1; k <= 12 && got_lat < 0; k++) begin
            s_ack  = (v.resp == 0 && k == v.lat);
            s_err  = (v.resp == 1 && k == v.lat);
            s_rdat = v.rdata;
            settle();
            if (f_ack(v.m) || f_err(v.m)) begin
                got_lat = k;
                got_ack = f_ack(v.m);
                got_err = f_err(v.m);
                got_dat = f_dat(v.m);
            end
            step();
        end
        s_ack = 1'b0; s_err = 1'b0;
        m_cyc[v.m] = 1'b0;
        step();
        check($sformatf("vec%0d_adr", idx), 64'(seen_adr), 64'(v.adr));
        check($sformatf("vec%0d_ack", idx), 64'(got_ack), 64'(v.e_ack));
        check($sformatf("vec%0d_err", idx), 64'(got_err), 64'(v.e_err));
        check($sformatf("vec%0d_lat", idx), 64'(got_lat), 64'(v.e_lat));
        if (!v.we && v.e_ack) begin
            check($sformatf("vec%0d_rdat", idx), 64'(got_dat), 64'(v.e_rdat));
        end
    endtask

    // Reference model state: who owns the bus, whether a request is in
    // flight, and how many cycles have elapsed since it was accepted.
    int   owner, last_owner, age, o, pulses, issued, acked, pend;
    logic outstanding, c, timed_out;
    logic [1:0]  e_grant, e_ack, e_err, e_stall;
    logic        e_scyc, e_sstb, e_swe;
    logic [31:0] e_sadr, e_swdat;
    logic [3:0]  e_ssel;
    logic [31:0] e_dat [2];

    initial begin
        tbl[0] = '{0, 1'b1, 32'h4,   32'h2,        1, 0, 32'h0,        1'b1, 1'b0, 1, 32'h0};
        tbl[1] = '{1, 1'b0, 32'h10,  32'h0,        3, 0, 32'hCAFE0001, 1'b1, 1'b0, 3, 32'hCAFE0001};
        tbl[2] = '{0, 1'b0, 32'h20,  32'h0,        2, 1, 32'h0,        1'b0, 1'b1, 2, 32'h0};
        tbl[3] = '{1, 1'b1, 32'h24,  32'h55AA55AA, 7, 0, 32'h0,        1'b1, 1'b0, 7, 32'h0};
        tbl[4] = '{0, 1'b0, 32'h28,  32'h0,        0, 2, 32'h0,        1'b0, 1'b1, TO, 32'h0};
        tbl[5] = '{1, 1'b0, 32'h2C,  32'h0,        0, 2, 32'h0,        1'b0, 1'b1, TO, 32'h0};
        tbl[6] = '{0, 1'b0, 32'h30,  32'h0,        5, 0, 32'h12345678, 1'b1, 1'b0, 5, 32'h12345678};

        do_reset();

        // Reset values
        settle();
        check("rst_grant", 64'(grant), 64'(2'b00));
        check("rst_scyc", 64'(s_cyc), 64'(0));
        check("rst_sstb", 64'(s_stb), 64'(0));
        check("rst_stall", 64'({m1_stall, m0_stall}), 64'(2'b11));
        check("rst_ackerr", 64'({m1_ack, m0_ack, m1_err, m0_err}), 64'(0));
        step();

        // M0 single write
        drive_m(0, 1'b1, 1'b1, 1'b1, 32'h4, 32'h2);
        settle();
        check("t1_grant_idle", 64'(grant), 64'(2'b00));
        check("t1_sstb_idle", 64'(s_stb), 64'(0));
        step();
        settle();
        check("t1_grant", 64'(grant), 64'(2'b01));
        check("t1_sstb", 64'(s_stb), 64'(1));
        check("t1_sbus", 64'({s_we, s_adr, s_wdat}), 64'({1'b1, 32'h4}) << 32 | 64'(32'h2));
        check("t1_stall_grant", 64'(m0_stall), 64'(0));
        step();
        m_stb[0] = 1'b0;
        settle();
        check("t1_sstb_wait", 64'(s_stb), 64'(0));
        check("t1_stall_wait", 64'(m0_stall), 64'(1));
        check("t1_no_early_ack", 64'(m0_ack), 64'(0));
        step();
        s_ack = 1'b1;
        settle();
        check("t1_m0_ack", 64'(m0_ack), 64'(1));
        check("t1_m1_ack", 64'(m1_ack), 64'(0));
        check("t1_m1_stall", 64'(m1_stall), 64'(1));
        step();
        s_ack = 1'b0;
        m_cyc[0] = 1'b0;
        settle();
        check("t1_scyc_drop", 64'(s_cyc), 64'(0));
        step();
        settle();
        check("t1_grant_end", 64'(grant), 64'(2'b00));

        // Table-driven single transfers
        for (int i = 0; i < 7; i++) begin
            run_vec(i, tbl[i]);
        end

        // Tie after reset: M0, idle, M1, then M0 again
        do_reset();
        drive_m(0, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0);
        drive_m(1, 1'b1, 1'b1, 1'b0, 32'h200, 32'h0);
        step();
        settle();
        check("t2_first_m0", 64'(grant), 64'(2'b01));
        check("t2_adr_m0", 64'(s_adr), 64'(32'h100));
        step();
        m_stb[0] = 1'b0;
        s_ack = 1'b1;
        settle();
        check("t2_ack_m0", 64'({m1_ack, m0_ack}), 64'(2'b01));
        step();
        s_ack = 1'b0;
        m_cyc[0] = 1'b0;
        step();
        settle();
        check("t2_idle_gap", 64'(grant), 64'(2'b00));
        step();
        settle();
        check("t2_then_m1", 64'(grant), 64'(2'b10));
        check("t2_adr_m1", 64'(s_adr), 64'(32'h200));
        step();
        m_stb[1] = 1'b0;
        s_ack = 1'b1;
        settle();
        check("t2_ack_m1", 64'({m1_ack, m0_ack}), 64'(2'b10));
        step();
        s_ack = 1'b0;
        m_cyc[1] = 1'b0;
        step();
        drive_m(0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
        drive_m(1, 1'b1, 1'b0, 1'b0, 32'h200, 32'h0);
        step();
        settle();
        check("t2_next_tie_m0", 64'(grant), 64'(2'b01));
        m_cyc = 2'b00;
        step();
        step();

        // M0 back-to-back reads, slave acks 2 cycles after each accept
        pulses = 0; issued = 0; acked = 0; pend = -1;
        drive_m(0, 1'b1, 1'b1, 1'b0, 32'h30, 32'h0);
        step();
        for (int n = 0; n < 40 && acked < 3; n++) begin
            s_ack    = (pend == 2);
            s_rdat   = 32'hA0000000 + 32'(acked);
            m_stb[0] = (issued < 3);
            m_adr[0] = 32'h30 + 32'(issued * 4);
            settle();
            if (s_stb) pulses++;
            if (pend >= 1) check($sformatf("t3_stall_wait%0d", n), 64'(m0_stall), 64'(1));
            if (m0_ack) begin
                check($sformatf("t3_rdat%0d", acked), 64'(m0_rdat), 64'(32'hA0000000 + 32'(acked)));
                acked++;
            end
            if (m1_ack) check("t3_m1_ack", 64'(m1_ack), 64'(0));
            if (m_stb[0] && !m0_stall) begin
                issued++;
                pend = 1;
            end else if (s_ack) begin
                pend = -1;
            end else if (pend >= 1) begin
                pend++;
            end
            step();
        end
        s_ack = 1'b0;
        check("t3_stb_pulses", 64'(pulses), 64'(3));
        check("t3_acks", 64'(acked), 64'(3));
        drive_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        step();

        // Watchdog timeout then late ack
        drive_m(0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0);
        step();
        step();
        m_stb[0] = 1'b0;
        for (int k = 1; k <= TO; k++) begin
            settle();
            if (k == TO - 1) begin
                check("t4_pre_err", 64'(m0_err), 64'(0));
                check("t4_pre_scyc", 64'(s_cyc), 64'(1));
            end
            if (k == TO) begin
                check("t4_err", 64'(m0_err), 64'(1));
                check("t4_scyc_low", 64'(s_cyc), 64'(0));
            end
            step();
        end
        s_ack = 1'b1;
        s_rdat = 32'h00000BAD;
        settle();
        check("t4_late_ack", 64'({m0_ack, m0_err}), 64'(0));
        check("t4_scyc_back", 64'(s_cyc), 64'(1));
        step();
        s_ack = 1'b0;
        m_cyc[0] = 1'b0;
        step();
        step();

        // Granted M1 abandons its cycle in WAIT while M0 waits
        drive_m(1, 1'b1, 1'b1, 1'b0, 32'h500, 32'h0);
        step();
        drive_m(0, 1'b1, 1'b1, 1'b0, 32'h600, 32'h0);
        settle();
        check("t5_grant_m1", 64'(grant), 64'(2'b10));
        check("t5_adr_m1", 64'(s_adr), 64'(32'h500));
        check("t5_m0_stalled", 64'(m0_stall), 64'(1));
        step();
        m_stb[1] = 1'b0;
        m_cyc[1] = 1'b0;
        s_ack = 1'b1;
        s_rdat = 32'h0000DEAD;
        settle();
        check("t5_m1_no_resp", 64'({m1_ack, m1_err}), 64'(0));
        step();
        settle();
        check("t5_scyc_low", 64'(s_cyc), 64'(0));
        check("t5_idle", 64'(grant), 64'(2'b00));
        check("t5_no_resp", 64'({m1_ack, m1_err, m0_ack, m0_err}), 64'(0));
        step();
        s_ack = 1'b0;
        settle();
        check("t5_m0_granted", 64'(grant), 64'(2'b01));
        step();
        drive_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        step();

        // Reset during WAIT
        drive_m(0, 1'b1, 1'b1, 1'b0, 32'h70, 32'h0);
        step();
        step();
        m_stb[0] = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        s_ack = 1'b1;
        settle();
        check("t6_grant", 64'(grant), 64'(2'b00));
        check("t6_slave", 64'({s_cyc, s_stb}), 64'(0));
        check("t6_m0", 64'({m0_ack, m0_err, m0_stall}), 64'(3'b001));
        m_cyc[0] = 1'b0;
        s_ack = 1'b0;
        step();
        step();

        // Randomized run against the reference model
        do_reset();
        owner = -1; last_owner = 1; age = 0; outstanding = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (m_cyc[i]) m_cyc[i] = ($urandom_range(0, 99) < 96);
                else          m_cyc[i] = ($urandom_range(0, 99) < 30);
                m_stb[i]  = m_cyc[i] & 1'($urandom_range(0, 1));
                m_we[i]   = 1'($urandom_range(0, 1));
                m_adr[i]  = $urandom;
                m_wdat[i] = $urandom;
                m_sel[i]  = 4'($urandom);
            end
            s_stall = ($urandom_range(0, 3) == 0);
            s_ack   = ($urandom_range(0, 4) == 0);
            s_err   = !s_ack && ($urandom_range(0, 19) == 0);
            s_rdat  = $urandom;
            settle();

            e_grant = 2'b00; e_scyc = 1'b0; e_sstb = 1'b0; e_swe = 1'b0;
            e_sadr = 32'h0; e_ssel = 4'h0; e_swdat = 32'h0;
            e_ack = 2'b00; e_err = 2'b00; e_stall = 2'b11;
            e_dat[0] = 32'h0; e_dat[1] = 32'h0;
            timed_out = outstanding && (age >= TO) && !s_ack && !s_err;
            c = 1'b0;
            if (owner >= 0) begin
                o = owner;
                c = m_cyc[o];
                e_grant = (o == 0) ? 2'b01 : 2'b10;
                e_sadr = m_adr[o]; e_ssel = m_sel[o]; e_swe = m_we[o]; e_swdat = m_wdat[o];
                e_dat[o] = s_rdat;
                if (!outstanding) begin
                    e_scyc = c;
                    e_sstb = c & m_stb[o];
                    e_stall[o] = s_stall;
                end else begin
                    e_scyc = c && !timed_out;
                    if (c) begin
                        e_ack[o] = s_ack;
                        e_err[o] = s_err | timed_out;
                    end
                end
            end
            check($sformatf("rnd_sbus@%0d", n), 64'({grant, s_cyc, s_stb, s_we, s_sel, s_adr}),
                  64'({e_grant, e_scyc, e_sstb, e_swe, e_ssel, e_sadr}));
            check($sformatf("rnd_swdat@%0d", n), 64'(s_wdat), 64'(e_swdat));
            check($sformatf("rnd_m0@%0d", n), 64'({m0_stall, m0_ack, m0_err, m0_rdat}),
                  64'({e_stall[0], e_ack[0], e_err[0], e_dat[0]}));
            check($sformatf("rnd_m1@%0d", n), 64'({m1_stall, m1_ack, m1_err, m1_rdat}),
                  64'({e_stall[1], e_ack[1], e_err[1], e_dat[1]}));

            if (owner < 0) begin
                if (m_cyc == 2'b11)  owner = (last_owner == 0) ? 1 : 0;
                else if (m_cyc[0])   owner = 0;
                else if (m_cyc[1])   owner = 1;
                outstanding = 1'b0;
                age = 0;
            end else if (!c) begin
                last_owner = owner;
                owner = -1;
                outstanding = 1'b0;
                age = 0;
            end else if (!outstanding) begin
                if (m_stb[owner] && !s_stall) begin
                    outstanding = 1'b1;
                    age = 1;
                end
            end else if (s_ack || s_err || age >= TO) begin
                outstanding = 1'b0;
                age = 0;
            end else begin
                age = age + 1;
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
